// File: rtl/nasti_stream_mux.sv
// Packet-level N-to-1 NASTI stream multiplexer with round-robin arbitration.
// A granted port owns the output until its t_last beat is accepted.
module nasti_stream_mux #(
    parameter int unsigned N_PORT       = 2,
    parameter int unsigned SELECT_WIDTH = (N_PORT > 1) ? $clog2(N_PORT) : 1,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ID_WIDTH     = 4,
    parameter int unsigned DEST_WIDTH   = 4,
    parameter int unsigned USER_WIDTH   = 1
) (
    input  logic                                    i_aclk,
    input  logic                                    i_areset,
    input  logic                                    i_enable,
    // upstream lanes
    input  logic [N_PORT-1:0][DATA_WIDTH-1:0]       i_m_t_data,
    input  logic [N_PORT-1:0][DATA_WIDTH/8-1:0]     i_m_t_strb,
    input  logic [N_PORT-1:0][DATA_WIDTH/8-1:0]     i_m_t_keep,
    input  logic [N_PORT-1:0]                       i_m_t_last,
    input  logic [N_PORT-1:0][ID_WIDTH-1:0]         i_m_t_id,
    input  logic [N_PORT-1:0][DEST_WIDTH-1:0]       i_m_t_dest,
    input  logic [N_PORT-1:0][USER_WIDTH-1:0]       i_m_t_user,
    input  logic [N_PORT-1:0]                       i_m_t_valid,
    output logic [N_PORT-1:0]                       o_m_t_ready,
    // downstream lane
    output logic [DATA_WIDTH-1:0]                   o_s_t_data,
    output logic [DATA_WIDTH/8-1:0]                 o_s_t_strb,
    output logic [DATA_WIDTH/8-1:0]                 o_s_t_keep,
    output logic                                    o_s_t_last,
    output logic [ID_WIDTH-1:0]                     o_s_t_id,
    output logic [DEST_WIDTH-1:0]                   o_s_t_dest,
    output logic [USER_WIDTH-1:0]                   o_s_t_user,
    output logic                                    o_s_t_valid,
    input  logic                                    i_s_t_ready,
    // status
    output logic                                    o_busy,
    output logic [SELECT_WIDTH-1:0]                 o_grant
);

    typedef enum logic {
        StIdle,
        StLocked
    } state_e;

    state_e                  r_state;
    state_e                  w_state_next;
    logic [SELECT_WIDTH-1:0] r_grant;
    logic [SELECT_WIDTH-1:0] w_grant_next;
    logic [SELECT_WIDTH-1:0] r_rr_ptr;
    logic [SELECT_WIDTH-1:0] w_rr_next;
    logic                    w_req_any;
    logic [SELECT_WIDTH-1:0] w_pick;
    logic [SELECT_WIDTH-1:0] w_idx;
    int unsigned             w_sum;

    // First requester scanning from r_rr_ptr upward, wrapping at N_PORT.
    always_comb begin
        w_req_any = 1'b0;
        w_pick    = '0;
        w_sum     = 0;
        w_idx     = '0;
        for (int unsigned k = 0; k < N_PORT; k++) begin
            w_sum = 32'(r_rr_ptr) + k;
            if (w_sum >= N_PORT) begin
                w_sum = w_sum - N_PORT;
            end
            w_idx = SELECT_WIDTH'(w_sum);
            if (!w_req_any && i_m_t_valid[w_idx]) begin
                w_req_any = 1'b1;
                w_pick    = w_idx;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_rr_next    = r_rr_ptr;
        o_s_t_valid  = 1'b0;
        o_m_t_ready  = '0;
        unique case (r_state)
            StIdle: begin
                if (i_enable && w_req_any) begin
                    w_state_next = StLocked;
                    w_grant_next = w_pick;
                end
            end
            StLocked: begin
                o_s_t_valid          = i_m_t_valid[r_grant];
                o_m_t_ready[r_grant] = i_s_t_ready;
                if (i_m_t_valid[r_grant] && i_s_t_ready && i_m_t_last[r_grant]) begin
                    w_state_next = StIdle;
                    w_rr_next    = (r_grant == SELECT_WIDTH'(N_PORT - 1)) ? '0
                                 : r_grant + SELECT_WIDTH'(1);
                end
            end
        endcase
    end

    always_ff @(posedge i_aclk or posedge i_areset) begin
        if (i_areset) begin
            r_state  <= StIdle;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_next;
            r_grant  <= w_grant_next;
            r_rr_ptr <= w_rr_next;
        end
    end

    // Payload mirrors the granted lane even in IDLE; valid/ready gate it.
    assign o_s_t_data = i_m_t_data[r_grant];
    assign o_s_t_strb = i_m_t_strb[r_grant];
    assign o_s_t_keep = i_m_t_keep[r_grant];
    assign o_s_t_last = i_m_t_last[r_grant];
    assign o_s_t_id   = i_m_t_id[r_grant];
    assign o_s_t_dest = i_m_t_dest[r_grant];
    assign o_s_t_user = i_m_t_user[r_grant];

    assign o_busy  = (r_state == StLocked);
    assign o_grant = r_grant;

endmodule

// File: tb/tb_nasti_stream_mux.sv
// Directed self-checking bench for nasti_stream_mux with three upstream ports.
module tb_nasti_stream_mux;

    logic             clk = 1'b0;
    logic             areset;
    logic             enable;
    logic [2:0][31:0] m_data;
    logic [2:0][3:0]  m_strb;
    logic [2:0][3:0]  m_keep;
    logic [2:0]       m_last;
    logic [2:0][3:0]  m_id;
    logic [2:0][3:0]  m_dest;
    logic [2:0][1:0]  m_user;
    logic [2:0]       m_valid;
    logic [2:0]       m_ready;
    logic [31:0]      s_data;
    logic [3:0]       s_strb;
    logic [3:0]       s_keep;
    logic             s_last;
    logic [3:0]       s_id;
    logic [3:0]       s_dest;
    logic [1:0]       s_user;
    logic             s_valid;
    logic             s_ready;
    logic             busy;
    logic [1:0]       grant;

    int n_checks = 0;
    int n_errors = 0;

    nasti_stream_mux #(
        .N_PORT     (3),
        .DATA_WIDTH (32),
        .ID_WIDTH   (4),
        .DEST_WIDTH (4),
        .USER_WIDTH (2)
    ) dut (
        .i_aclk      (clk),
        .i_areset    (areset),
        .i_enable    (enable),
        .i_m_t_data  (m_data),
        .i_m_t_strb  (m_strb),
        .i_m_t_keep  (m_keep),
        .i_m_t_last  (m_last),
        .i_m_t_id    (m_id),
        .i_m_t_dest  (m_dest),
        .i_m_t_user  (m_user),
        .i_m_t_valid (m_valid),
        .o_m_t_ready (m_ready),
        .o_s_t_data  (s_data),
        .o_s_t_strb  (s_strb),
        .o_s_t_keep  (s_keep),
        .o_s_t_last  (s_last),
        .o_s_t_id    (s_id),
        .o_s_t_dest  (s_dest),
        .o_s_t_user  (s_user),
        .o_s_t_valid (s_valid),
        .i_s_t_ready (s_ready),
        .o_busy      (busy),
        .o_grant     (grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int          bt[3];
    int          pn[3];
    int          got;
    int          pkt;
    int          port;
    int          beat;
    logic [2:0]  fired;
    logic [31:0] bp_pat;

    initial begin
        areset  = 1'b1;
        enable  = 1'b0;
        s_ready = 1'b0;
        m_data  = '0;
        m_strb  = '0;
        m_keep  = '0;
        m_last  = '0;
        m_id    = '0;
        m_dest  = '0;
        m_user  = '0;
        m_valid = '0;
        #3;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_svalid", 32'(s_valid), 0);
        chk("rst_mready", 32'(m_ready), 0);
        tick;
        tick;
        areset  = 1'b0;
        enable  = 1'b1;
        s_ready = 1'b1;
        #1;

        // Single 4-beat packet on port 2
        m_valid[2] = 1'b1;
        m_data[2]  = 32'hA0;
        m_last[2]  = 1'b0;
        #1;
        chk("ss_idle_busy", 32'(busy), 0);
        chk("ss_idle_svalid", 32'(s_valid), 0);
        for (int b = 0; b < 4; b++) begin
            tick;
            m_data[2] = 32'hA0 + 32'(b);
            m_last[2] = (b == 3);
            #1;
            chk("ss_busy", 32'(busy), 1);
            chk("ss_grant", 32'(grant), 2);
            chk("ss_svalid", 32'(s_valid), 1);
            chk("ss_data", s_data, 32'hA0 + 32'(b));
            chk("ss_last", 32'(s_last), (b == 3) ? 1 : 0);
            chk("ss_mready", 32'(m_ready), 32'b100);
        end
        tick;
        m_valid[2] = 1'b0;
        m_last[2]  = 1'b0;
        #1;
        chk("ss_end_busy", 32'(busy), 0);
        chk("ss_end_grant", 32'(grant), 2);
        chk("ss_end_svalid", 32'(s_valid), 0);

        // Round-robin: all ports offer 2-beat packets back to back
        for (int i = 0; i < 3; i++) begin
            bt[i]      = 0;
            pn[i]      = 0;
            m_valid[i] = 1'b1;
            m_data[i]  = 32'(i * 256);
            m_last[i]  = 1'b0;
        end
        #1;
        for (int c = 0; c < 18; c++) begin
            chk("rr_svalid", 32'(s_valid), (c % 3 != 0) ? 1 : 0);
            if (c % 3 != 0) begin
                pkt  = c / 3;
                port = pkt % 3;
                beat = c % 3 - 1;
                chk("rr_data", s_data, 32'(port * 256 + (pkt / 3) * 16 + beat));
                chk("rr_last", 32'(s_last), (beat == 1) ? 1 : 0);
                chk("rr_mready", 32'(m_ready), 32'(1 << port));
            end else begin
                chk("rr_mready_idle", 32'(m_ready), 0);
            end
            fired = m_valid & m_ready;
            tick;
            for (int i = 0; i < 3; i++) begin
                if (fired[i]) begin
                    if (bt[i] == 1) begin
                        bt[i] = 0;
                        pn[i]++;
                    end else begin
                        bt[i]++;
                    end
                end
                m_data[i] = 32'(i * 256 + pn[i] * 16 + bt[i]);
                m_last[i] = (bt[i] == 1);
            end
            #1;
        end
        m_valid = '0;
        m_last  = '0;
        #1;

        // Backpressure: port 1 sends 8 beats under a toggling ready
        bp_pat     = 32'b1011_0010_1110_0101_1001_1100_0111_0110;
        got        = 0;
        m_valid[1] = 1'b1;
        m_data[1]  = 32'hB0;
        m_last[1]  = 1'b0;
        for (int c = 0; c < 48 && got < 8; c++) begin
            s_ready = bp_pat[c];
            #1;
            chk("bp_mready0", 32'(m_ready[0]), 0);
            chk("bp_mready2", 32'(m_ready[2]), 0);
            if (s_valid && s_ready) begin
                chk("bp_data", s_data, 32'hB0 + 32'(got));
                chk("bp_last", 32'(s_last), (got == 7) ? 1 : 0);
            end
            fired = m_valid & m_ready;
            tick;
            if (fired[1]) begin
                got++;
                m_data[1] = 32'hB0 + 32'(got);
                m_last[1] = (got == 7);
                if (got == 8) begin
                    m_valid[1] = 1'b0;
                    m_last[1]  = 1'b0;
                end
            end
        end
        chk("bp_count", 32'(got), 8);
        s_ready = 1'b1;
        #1;

        // Enable gating
        enable     = 1'b0;
        m_valid[0] = 1'b1;
        m_data[0]  = 32'hD0;
        m_last[0]  = 1'b0;
        m_valid[2] = 1'b1;
        m_data[2]  = 32'hE0;
        m_last[2]  = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            tick;
            chk("en_off_busy", 32'(busy), 0);
            chk("en_off_svalid", 32'(s_valid), 0);
            chk("en_off_mready", 32'(m_ready), 0);
        end
        enable = 1'b1;
        #1;
        for (int b = 0; b < 5; b++) begin
            tick;
            m_data[2] = 32'hE0 + 32'(b);
            m_last[2] = (b == 4);
            if (b == 2) enable = 1'b0;
            #1;
            chk("en_busy", 32'(busy), 1);
            chk("en_grant", 32'(grant), 2);
            chk("en_data", s_data, 32'hE0 + 32'(b));
            chk("en_last", 32'(s_last), (b == 4) ? 1 : 0);
        end
        tick;
        m_valid[2] = 1'b0;
        m_last[2]  = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("en_hold_busy", 32'(busy), 0);
            chk("en_hold_grant", 32'(grant), 2);
            tick;
        end
        m_valid[0] = 1'b0;
        enable     = 1'b1;
        #1;

        // Side-band passthrough on port 1
        m_valid[1] = 1'b1;
        m_id[1]    = 4'd3;
        m_dest[1]  = 4'd5;
        m_user[1]  = 2'd1;
        m_strb[1]  = 4'hF;
        m_keep[1]  = 4'hF;
        m_data[1]  = 32'hC0;
        m_last[1]  = 1'b0;
        tick;
        for (int b = 0; b < 2; b++) begin
            m_data[1] = 32'hC0 + 32'(b);
            m_last[1] = (b == 1);
            #1;
            chk("sb_grant", 32'(grant), 1);
            chk("sb_data", s_data, 32'hC0 + 32'(b));
            chk("sb_id", 32'(s_id), 3);
            chk("sb_dest", 32'(s_dest), 5);
            chk("sb_user", 32'(s_user), 1);
            chk("sb_strb", 32'(s_strb), 32'hF);
            chk("sb_keep", 32'(s_keep), 32'hF);
            tick;
        end

        // Reset mid-packet with port 1 locked
        m_data[1] = 32'hC8;
        m_last[1] = 1'b0;
        tick;
        chk("mr_busy", 32'(busy), 1);
        chk("mr_grant", 32'(grant), 1);
        tick;
        areset = 1'b1;
        #1;
        chk("mr_rst_busy", 32'(busy), 0);
        chk("mr_rst_grant", 32'(grant), 0);
        chk("mr_rst_svalid", 32'(s_valid), 0);
        chk("mr_rst_mready", 32'(m_ready), 0);
        m_valid = 3'b111;
        tick;
        areset = 1'b0;
        #1;
        chk("mr_rel_busy", 32'(busy), 0);
        tick;
        chk("mr_first_busy", 32'(busy), 1);
        chk("mr_first_grant", 32'(grant), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nasti_stream_mux.md
# nasti_stream_mux

Packet-level N-to-1 multiplexer for NASTI stream channels: merges N_PORT upstream streams onto one downstream stream. It is the converging counterpart of the stream demultiplexer and sits where several stream producers (DMA engines, peripherals) share one consumer. Arbitration is round-robin. A granted port keeps the output until its `t_last` beat is accepted, so packets are never interleaved.

## Interface
- `N_PORT`, default 2: number of upstream stream ports; must be at least 2.
- `SELECT_WIDTH`, default `$clog2(N_PORT)`: width of the grant index.
- `aclk`  in  1  clock; all logic is on the rising edge.
- `areset`  in  1  asynchronous, active-high reset.
- `master`  `nasti_stream_channel.slave`  N_PORT lanes: upstream inputs. Lane i carries `t_data`, `t_strb`, `t_keep`, `t_last`, `t_id`, `t_dest`, `t_user`, `t_valid` in, and `t_ready` out.
- `slave`  `nasti_stream_channel.master`  lane [0] only: downstream output. The instance uses N_PORT=1.
- `enable`  in  1  permits new arbitration; it is sampled only in IDLE.
- `busy`  out  1  high while a packet is locked (LOCKED state).
- `grant`  out  SELECT_WIDTH  index of the currently or most recently granted port.

## Operation
- State machine with two states, IDLE and LOCKED, plus registers `grant_q` and `rr_ptr` (round-robin pointer).
- **IDLE**
  - If `enable` is high and any `master.t_valid[i]` is high, pick the first requesting port scanning `rr_ptr`, `rr_ptr+1`, … modulo N_PORT.
  - Load the pick into `grant_q` and go to LOCKED on the next edge.
  - Otherwise stay in IDLE.
- **LOCKED**
  - `slave.t_data[0]` through `slave.t_user[0]` equal `master.*[grant_q]`, combinationally.
  - `slave.t_valid[0] = master.t_valid[grant_q]`.
  - `master.t_ready[i] = (i == grant_q) ? slave.t_ready[0] : 0`.
  - When a beat transfers (valid && ready) with `t_last` high: go to IDLE and set `rr_ptr <= (grant_q == N_PORT-1) ? 0 : grant_q + 1`.
- In IDLE, `slave.t_valid[0] = 0` and every `master.t_ready[i] = 0`. The data lanes still mirror `master[grant_q]`; the value is don't-care.
- `busy = (state == LOCKED)`. `grant = grant_q`.
- No data buffering: payload passes straight through, with zero combinational added latency once locked.
- The block never drops, duplicates or reorders a beat. Side-band fields (`t_id`, `t_dest`, `t_user`) pass through unchanged.

## Timing
- **Reset value** (asynchronous, while `areset` is high):
  - state IDLE, `grant_q` 0, `rr_ptr` 0;
  - `busy` 0, `grant` 0;
  - `slave.t_valid[0]` 0, all `master.t_ready` 0.
- **Arbitration latency:** `t_valid` on port i seen at edge k gives LOCKED after edge k. The first beat can transfer in the cycle after edge k, i.e. one bubble cycle.
- **Inter-packet gap:** the `t_last` transfer at edge m returns to IDLE. The next grant is decided in the cycle after edge m and its first beat transfers one cycle after that. Minimum gap is therefore one idle cycle between packets.
- **Single-beat packet** (`t_last` on the first beat): LOCKED lasts exactly one cycle if `slave.t_ready` is high.
- **`enable` deasserted while LOCKED:** no effect; the packet completes. `enable` low in IDLE blocks all grants.
- **Upstream `t_valid` dropping mid-packet** (AXIS violation, tolerated): the lock holds and `slave.t_valid` follows it.
- **Requests on non-granted ports while LOCKED:** ignored. Their `t_ready` stays 0, so they stall.
- **`rr_ptr` wrap-around:** from N_PORT-1 it goes to 0. This is correct for non-power-of-2 N_PORT; indices of N_PORT or above never occur.
- **`areset` mid-packet:** the packet is abandoned immediately. Outputs return to reset values and the next grant starts from port 0.

## Test plan
- **Reset:** assert `areset` mid-packet with N_PORT=3 and port 1 locked -> `busy`=0, `grant`=0, `slave.t_valid`=0 and all `t_ready`=0 within the same cycle. After release, port 0 wins first.
- **Single stream:** port 2 sends a 4-beat packet, data 0xA0..0xA3, with `slave.t_ready`=1 -> `busy` rises one cycle after `t_valid`. Exactly 4 output beats, data 0xA0..0xA3, `t_last` on 0xA3. `rr_ptr` becomes 0 (wrap).
- **Round-robin fairness:** all three ports continuously offer 2-beat packets -> output packet order 0,1,2,0,1,2 with one idle cycle between packets, and no interleaving within a packet.
- **Backpressure:** toggle `slave.t_ready` pseudo-randomly while port 1 sends 8 beats -> all 8 beats arrive in order. Ports 0 and 2 see `t_ready`=0 throughout.
- **Enable gating:** hold `enable`=0 while ports request -> no grant and `busy`=0. Drop `enable` during the 3rd beat of a 5-beat packet -> all 5 beats complete, then no new grant.
- **Side-band passthrough:** port 1 sends `t_id`=3, `t_dest`=5, `t_user`=1, `t_strb`=0x0F, `t_keep`=0x0F -> identical values appear on the slave lane for every beat.
